weight_fetch_ctrl: RTL and testbench

Sequencer for one per-block convolution weight ROM. The ROM has a synchronous read, a 1-cycle latency and an `enable` input. On `start` the block walks the ROM over a contiguous window of words for a programmable number of passes. It delivers the words to the binary-conv PE array over a valid/ready stream with full backpressure support. It sits between the layer controller, which issues `start`, and the ROM/PE pair.

---
 rtl/weight_fetch_ctrl_pkg.sv | 19 +
 rtl/weight_skid_fifo.sv | 44 ++++
 rtl/weight_fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_weight_fetch_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_fetch_ctrl_pkg.sv
// Shared types for the weight ROM sequencer: FSM encoding and the layout of
// one output-buffer entry {data, pass_end, last}.
package weight_fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } state_e;

   localparam int unsigned PassEndW = 1;
   localparam int unsigned LastW    = 1;

   function automatic int unsigned entry_width(input int unsigned data_width);
      return data_width + PassEndW + LastW;
   endfunction

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry synchronous FIFO. The producer must never push while full;
// simultaneous push and pop are allowed at any fill level.
module weight_skid_fifo
   import weight_fetch_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = entry_width(32)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= din;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Walks a window of a 1-cycle-latency weight ROM for N passes and streams the
// words out over valid/ready, issuing reads only when the 2-entry buffer has room.
module weight_fetch_ctrl
   import weight_fetch_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned PASS_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   num_words,
   input  logic [PASS_WIDTH-1:0] num_passes,
   output logic                  busy,
   output logic                  done,
   output logic                  rom_en,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic                  w_valid,
   output logic [DATA_WIDTH-1:0] w_data,
   output logic                  w_pass_end,
   output logic                  w_last,
   input  logic                  w_ready
);

   localparam int unsigned EntryW = entry_width(DATA_WIDTH);
   localparam logic [ADDR_WIDTH:0]   WordOne = (ADDR_WIDTH + 1)'(1);
   localparam logic [PASS_WIDTH-1:0] PassOne = PASS_WIDTH'(1);
   localparam logic [2:0]            MaxOcc  = 3'd2;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH:0]   words_q, idx_q;
   logic [PASS_WIDTH-1:0] passes_q, pass_q;
   logic                  inflight_q, pend_pass_end_q, pend_last_q;

   logic                  issue, pop, word_last, pass_last;
   logic [1:0]            fifo_count;
   logic [2:0]            occ;
   logic [EntryW-1:0]     fifo_dout;

   assign pop       = w_valid && w_ready;
   assign word_last = (idx_q == words_q - WordOne);
   assign pass_last = (pass_q == passes_q - PassOne);
   // Occupancy the buffer will have next cycle if nothing new is issued now.
   assign occ       = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue     = (state_q == StFetch) && (occ < MaxOcc);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = (num_words == '0) ? StDone : StFetch;
            end
         end
         StFetch: begin
            if (issue && word_last && pass_last) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (pop && w_last) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy     = (state_q == StFetch) || (state_q == StDrain);
      done     = (state_q == StDone);
      rom_en   = issue;
      rom_addr = issue ? (base_q + idx_q[ADDR_WIDTH-1:0]) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base_q          <= '0;
         words_q         <= '0;
         passes_q        <= '0;
         idx_q           <= '0;
         pass_q          <= '0;
         inflight_q      <= 1'b0;
         pend_pass_end_q <= 1'b0;
         pend_last_q     <= 1'b0;
      end else begin
         if (state_q == StIdle && start) begin
            base_q   <= base_addr;
            words_q  <= num_words;
            passes_q <= (num_passes == '0) ? PassOne : num_passes;
            idx_q    <= '0;
            pass_q   <= '0;
         end else if (issue) begin
            if (word_last) begin
               idx_q  <= '0;
               pass_q <= pass_q + PassOne;
            end else begin
               idx_q <= idx_q + WordOne;
            end
         end
         // Flags travel alongside the read so they land with its data.
         inflight_q      <= issue;
         pend_pass_end_q <= issue && word_last;
         pend_last_q     <= issue && word_last && pass_last;
      end
   end

   weight_skid_fifo #(
      .WIDTH (EntryW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight_q),
      .din   ({rom_data, pend_pass_end_q, pend_last_q}),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

   assign w_valid                        = (fifo_count != 2'd0);
   assign {w_data, w_pass_end, w_last}   = fifo_dout;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl with a behavioural ROM and a beat scoreboard.
module tb_weight_fetch_ctrl;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          rst, start, busy, done, rom_en, w_valid, w_pass_end, w_last, w_ready;
   logic [AW-1:0] base_addr, rom_addr;
   logic [AW:0]   num_words;
   logic [PW-1:0] num_passes;
   logic [DW-1:0] rom_data, w_data;

   always #5 clk = ~clk;

   weight_fetch_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .PASS_WIDTH (PW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .num_words  (num_words),
      .num_passes (num_passes),
      .busy       (busy),
      .done       (done),
      .rom_en     (rom_en),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .w_valid    (w_valid),
      .w_data     (w_data),
      .w_pass_end (w_pass_end),
      .w_last     (w_last),
      .w_ready    (w_ready)
   );

   function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
      return {8'hC3, a, ~a, a ^ 8'h5A};
   endfunction

   always @(posedge clk) begin
      if (rom_en) rom_data <= rom_word(rom_addr);
   end

   logic [DW+1:0] exp_q[$];
   logic [AW-1:0] addr_log[$];
   logic [DW+1:0] prev_head;
   logic [AW-1:0] wrap_exp [4];
   int  checks = 0, passed = 0, failed = 0;
   int  cyc = 0, t_start = 0, done_cyc = 0, first_valid_cyc = -1, last_beat_cyc = 0;
   int  beats = 0, occ = 0;
   bit  prev_stall = 1'b0, saw_done = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample settled outputs mid-cycle, then advance to the next negedge.
   task automatic tick();
      logic          hs;
      logic [DW+1:0] head, e;
      #1;
      head = {w_data, w_pass_end, w_last};
      hs   = w_valid && w_ready;
      if (done) begin
         saw_done = 1'b1;
         done_cyc = cyc;
      end
      if (!rst) begin
         if (prev_stall) chk("stall_stable", head, prev_head);
         if (rom_en) begin
            addr_log.push_back(rom_addr);
            chk("credit", (occ + 1 - int'(hs)) <= 2, 1);
         end
         occ = occ + int'(rom_en) - int'(hs);
         if (w_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (hs) begin
            beats++;
            last_beat_cyc = cyc;
            chk("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("beat", head, e);
            end
         end
         prev_stall = w_valid && !w_ready;
         prev_head  = head;
      end else begin
         prev_stall = 1'b0;
         occ        = 0;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_start(input int b, input int n, input int p);
      int            pe;
      logic [AW-1:0] a;
      pe = (p == 0) ? 1 : p;
      if (n > 0) begin
         for (int pp = 0; pp < pe; pp++) begin
            for (int w = 0; w < n; w++) begin
               a = AW'(b + w);
               exp_q.push_back({rom_word(a), w == n - 1, (w == n - 1) && (pp == pe - 1)});
            end
         end
      end
      base_addr       = AW'(b);
      num_words       = (AW + 1)'(n);
      num_passes      = PW'(p);
      start           = 1'b1;
      beats           = 0;
      first_valid_cyc = -1;
      saw_done        = 1'b0;
      addr_log.delete();
      t_start = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, input bit bp);
      int k;
      k = 0;
      while (!saw_done && k < limit) begin
         if (bp) w_ready = (k >= 4 && k < 14) ? 1'b0 : 1'($urandom_range(0, 1));
         tick();
         k++;
      end
      w_ready = 1'b1;
      chk("done_seen", saw_done, 1);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rom_en", rom_en, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_w_valid", w_valid, 0);
      chk("rst_w_data", w_data, 0);
      chk("rst_w_pass_end", w_pass_end, 0);
      chk("rst_w_last", w_last, 0);
   endtask

   initial begin
      wrap_exp   = '{8'd254, 8'd255, 8'd0, 8'd1};
      rst        = 1'b1;
      start      = 1'b0;
      w_ready    = 1'b1;
      base_addr  = '0;
      num_words  = '0;
      num_passes = '0;
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;
      chk_reset_outputs();

      // Basic single pass
      do_start(5, 3, 1);
      chk("basic_busy_t1", busy, 1);
      chk("basic_rom_en_t1", rom_en, 1);
      chk("basic_rom_addr_t1", rom_addr, 5);
      wait_done(50, 1'b0);
      chk("basic_first_valid_lat", first_valid_cyc - t_start, 3);
      chk("basic_done_lat", done_cyc - t_start, 6);
      chk("basic_beats", beats, 3);
      chk("basic_sb_empty", exp_q.size(), 0);

      // Multi-pass, started two cycles after the previous w_last handshake
      do_start(0, 2, 3);
      wait_done(50, 1'b0);
      chk("multi_beats", beats, 6);
      chk("multi_back_to_back", last_beat_cyc - first_valid_cyc, 5);
      chk("multi_done_lat", done_cyc - t_start, 9);
      chk("multi_sb_empty", exp_q.size(), 0);

      // Address wrap
      do_start(254, 4, 1);
      wait_done(50, 1'b0);
      chk("wrap_reads", addr_log.size(), 4);
      for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("wrap_addr", addr_log[i], wrap_exp[i]);
      chk("wrap_sb_empty", exp_q.size(), 0);

      // Backpressure
      do_start(10, 7, 3);
      wait_done(600, 1'b1);
      chk("bp_beats", beats, 21);
      chk("bp_reads", addr_log.size(), 21);
      chk("bp_sb_empty", exp_q.size(), 0);

      // Zero words
      do_start(30, 0, 2);
      chk("zero_done_t1", done, 1);
      chk("zero_busy_t1", busy, 0);
      chk("zero_rom_en_t1", rom_en, 0);
      tick();
      tick();
      chk("zero_w_valid", w_valid, 0);
      chk("zero_beats", beats, 0);
      chk("zero_reads", addr_log.size(), 0);

      // Zero passes behaves as one
      do_start(20, 3, 0);
      wait_done(50, 1'b0);
      chk("p0_beats", beats, 3);
      chk("p0_done_lat", done_cyc - t_start, 6);
      chk("p0_sb_empty", exp_q.size(), 0);

      // start while busy is ignored
      do_start(40, 4, 2);
      tick();
      tick();
      base_addr  = 8'd100;
      num_words  = 9'd1;
      num_passes = 8'd1;
      start      = 1'b1;
      tick();
      start = 1'b0;
      wait_done(80, 1'b0);
      chk("busy_start_beats", beats, 8);
      chk("busy_start_done_lat", done_cyc - t_start, 11);
      chk("busy_start_sb_empty", exp_q.size(), 0);

      // Reset mid-run after two words, then a clean rerun
      do_start(60, 8, 1);
      for (int k = 0; k < 20 && beats < 2; k++) tick();
      chk("rst_mid_beats", beats, 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset_outputs();
      exp_q.delete();
      tick();
      chk("rst_mid_idle_w_valid", w_valid, 0);
      do_start(60, 8, 1);
      wait_done(80, 1'b0);
      chk("rerun_beats", beats, 8);
      chk("rerun_first_addr", addr_log.size() > 0 ? addr_log[0] : 8'hxx, 60);
      chk("rerun_done_lat", done_cyc - t_start, 11);
      chk("rerun_sb_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
